uart_cmd_bridge: RTL and testbench
==================================

// Module: uart_cmd_bridge
// PURPOSE
// - Sits downstream of the uartx2 RX path and upstream of its TX path; turns the UART byte stream into register-bus accesses.
// - Pops received bytes (read_rx) and parses frames: sync, cmd, addr, [data], checksum.
// - Performs a single bus read or write, then pushes a 2-byte response into the UART TX queue (write_tx).
// PARAMETERS
// - IDLE_TIMEOUT  default 100000  clk cycles allowed between bytes of one frame before abort
// - BUS_TIMEOUT   default 255     clk cycles allowed waiting for bus_ready before an error response
// PORTS
// - clk          in   1  clock
// - nreset       in   1  asynchronous, active-low reset
// - rx_valid     in   1  UART RX byte available
// - rxdata       in   8  UART RX byte
// - rx_status    in   8  UART status; bits [5:2] = noise/framing/parity/overrun of the current byte
// - read_rx      out  1  one-cycle pop of the current RX byte
// - tx_empty     in   1  UART TX holding register free
// - txdata       out  8  byte to transmit
// - write_tx     out  1  one-cycle push of txdata
// - bus_addr     out  8  register address
// - bus_wdata    out  8  write data
// - bus_wr       out  1  write strobe; held until bus_ready
// - bus_rd       out  1  read strobe; held until bus_ready
// - bus_rdata    in   8  read data, valid with bus_ready
// - bus_ready    in   1  access complete
// - err_count    out  8  saturating count of aborted or rejected frames
// BEHAVIOUR
// - Reset values: all outputs 0; FSM in HUNT; timers 0.
// - Frame format: 0xA5, CMD (0x01 = write, 0x02 = read), ADDR, DATA (write only), CSUM = CMD^ADDR^DATA (read: CMD^ADDR).
// - FSM states: HUNT, CMD, ADDR, DATA, CSUM, BUS, RSP0, RSP1.
//   - HUNT: any byte other than 0xA5 is popped and discarded (not counted as an error).
// - RX handshake:
//   - read_rx pulses for 1 cycle when rx_valid=1 and the FSM is in a byte-consuming state.
//   - The byte is captured in that same cycle.
//   - The cycle after a pulse is a mandatory gap (no pulse), because the UART drops rx_valid one clock later.
// - Byte errors: any of rx_status[5:2] set on a consumed byte -> err_count+1, go to HUNT. Applies in every state, including HUNT.
// - Unknown CMD or CSUM mismatch -> response 0xEE, 0x01; err_count+1.
// - Inter-byte timer:
//   - Cleared on every pop.
//   - Counts while in CMD, ADDR, DATA or CSUM.
//   - Reaching IDLE_TIMEOUT -> HUNT with no response; err_count+1.
// - BUS state:
//   - bus_wr or bus_rd asserts in the cycle after CSUM is accepted, with bus_addr/bus_wdata stable.
//   - The strobe deasserts in the cycle after bus_ready=1 is sampled.
//   - bus_rdata is captured on that bus_ready cycle.
//   - If bus_ready is still 0 after BUS_TIMEOUT cycles: drop the strobe; response 0xEE, 0x02; err_count+1.
// - Responses:
//   - Write OK = 0x5A, 0x00. Read OK = 0x5A, rdata.
//   - RSP0/RSP1: write_tx pulses when tx_empty=1, with txdata valid that cycle.
//   - One-cycle gap after each pulse; return to HUNT after the RSP1 push.
// - RX bytes arriving during BUS/RSP are not popped; they stay queued in the UART.
// - err_count saturates at 0xFF and is cleared only by reset.
// - Reset mid-frame or mid-access: FSM returns to HUNT immediately and strobes drop asynchronously.
// STRUCTURE
// - Shared package uart_bridge_pkg holds: SYNC_BYTE=8'hA5, ACK_BYTE=8'h5A, NAK_BYTE=8'hEE, CMD_WR=8'h01, CMD_RD=8'h02, NAK codes, and the FSM state enum.
// - Sub-module uart_bridge_timer: loadable down-counter with expiry flag, instantiated twice (inter-byte timer and bus timer).
// TESTING
// - Write: A5 01 10 3C 2D -> bus_wr with addr 0x10, wdata 0x3C; bus_ready after 3 cycles -> TX 5A 00; err_count stays 0.
// - Read: A5 02 20 22 with bus_rdata 0x77 -> bus_rd with addr 0x20 -> TX 5A 77.
// - Bad checksum: A5 01 10 3C 00 -> no bus strobe; TX EE 01; err_count=1.
// - Garbage then frame: 00 FF A5 02 20 22 -> the two leading bytes are discarded silently and the read completes normally.
// - Stall: A5 01, then nothing for IDLE_TIMEOUT cycles -> HUNT, no TX, err_count+1; the next full frame succeeds.
// - Bus hang: bus_ready held at 0 -> strobe drops after BUS_TIMEOUT cycles; TX EE 02.
// - Handshake: a back-to-back RX burst never produces read_rx on two consecutive cycles; tx_empty held at 0 delays write_tx until it rises.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared constants and FSM state type for the UART command bridge.
package uart_bridge_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h5A;
  localparam logic [7:0] NAK_BYTE  = 8'hEE;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] NAK_CSUM  = 8'h01;
  localparam logic [7:0] NAK_BUS   = 8'h02;

  typedef enum logic [2:0] {
    StHunt,
    StCmd,
    StAddr,
    StData,
    StCsum,
    StBus,
    StRsp0,
    StRsp1
  } state_e;

endpackage

// File: rtl/uart_bridge_timer.sv
// Loadable down-counter; o_expired flags a zero count.
module uart_bridge_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/uart_cmd_bridge.sv
// Parses sync/cmd/addr/[data]/csum frames from the UART RX queue, performs one
// register-bus access and pushes a two-byte response into the UART TX queue.
module uart_cmd_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = 100000,
  parameter int unsigned BUS_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       i_rx_valid,
  input  logic [7:0] i_rxdata,
  input  logic [7:0] i_rx_status,
  output logic       o_read_rx,
  input  logic       i_tx_empty,
  output logic [7:0] o_txdata,
  output logic       o_write_tx,
  output logic [7:0] o_bus_addr,
  output logic [7:0] o_bus_wdata,
  output logic       o_bus_wr,
  output logic       o_bus_rd,
  input  logic [7:0] i_bus_rdata,
  input  logic       i_bus_ready,
  output logic [7:0] o_err_count
);

  localparam int unsigned IdleW = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned BusW  = $clog2(BUS_TIMEOUT + 1);

  state_e     r_state, w_state_next;
  logic [7:0] r_cmd, w_cmd_next, r_addr, w_addr_next, r_data, w_data_next;
  logic [7:0] r_rsp0, w_rsp0_next, r_rsp1, w_rsp1_next, r_err;
  logic       r_bus_wr, w_bus_wr_next, r_bus_rd, w_bus_rd_next, r_gap;
  logic       w_err_inc, w_consume, w_idle_cnt, w_byte_err, w_tx_fire;
  logic       w_idle_exp, w_bus_exp, w_unused;
  logic [7:0] w_csum;

  assign w_consume  = r_state inside {StHunt, StCmd, StAddr, StData, StCsum};
  assign w_idle_cnt = r_state inside {StCmd, StAddr, StData, StCsum};
  assign w_byte_err = |i_rx_status[5:2];
  assign w_unused   = ^{i_rx_status[7:6], i_rx_status[1:0]};
  assign w_csum     = r_cmd ^ r_addr ^ ((r_cmd == CMD_WR) ? r_data : 8'h00);

  // r_gap enforces the idle cycle after every RX pop or TX push.
  assign o_read_rx  = i_rx_valid & w_consume & ~r_gap;
  assign w_tx_fire  = i_tx_empty & ~r_gap & (r_state inside {StRsp0, StRsp1});
  assign o_write_tx = w_tx_fire;
  assign o_txdata   = !w_tx_fire ? 8'h00 : (r_state == StRsp0) ? r_rsp0 : r_rsp1;

  assign o_bus_addr  = r_addr;
  assign o_bus_wdata = r_data;
  assign o_bus_wr    = r_bus_wr;
  assign o_bus_rd    = r_bus_rd;
  assign o_err_count = r_err;

  uart_bridge_timer #(.WIDTH(IdleW)) u_idle_timer (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (o_read_rx),
    .i_load_val (IdleW'(IDLE_TIMEOUT - 1)),
    .i_en       (w_idle_cnt),
    .o_expired  (w_idle_exp)
  );

  uart_bridge_timer #(.WIDTH(BusW)) u_bus_timer (
    .clk        (clk),
    .nreset     (nreset),
    .i_load     (r_state != StBus),
    .i_load_val (BusW'(BUS_TIMEOUT - 1)),
    .i_en       (r_state == StBus),
    .o_expired  (w_bus_exp)
  );

  always_comb begin
    w_state_next  = r_state;
    w_cmd_next    = r_cmd;
    w_addr_next   = r_addr;
    w_data_next   = r_data;
    w_rsp0_next   = r_rsp0;
    w_rsp1_next   = r_rsp1;
    w_bus_wr_next = r_bus_wr;
    w_bus_rd_next = r_bus_rd;
    w_err_inc     = 1'b0;
    if (o_read_rx) begin
      if (w_byte_err) begin
        w_err_inc    = 1'b1;
        w_state_next = StHunt;
      end else begin
        case (r_state)
          StHunt: if (i_rxdata == SYNC_BYTE) w_state_next = StCmd;
          StCmd: begin
            w_cmd_next = i_rxdata;
            if (i_rxdata == CMD_WR || i_rxdata == CMD_RD) begin
              w_state_next = StAddr;
            end else begin
              w_rsp0_next  = NAK_BYTE;
              w_rsp1_next  = NAK_CSUM;
              w_err_inc    = 1'b1;
              w_state_next = StRsp0;
            end
          end
          StAddr: begin
            w_addr_next  = i_rxdata;
            w_state_next = (r_cmd == CMD_WR) ? StData : StCsum;
          end
          StData: begin
            w_data_next  = i_rxdata;
            w_state_next = StCsum;
          end
          StCsum: begin
            if (i_rxdata == w_csum) begin
              w_bus_wr_next = (r_cmd == CMD_WR);
              w_bus_rd_next = (r_cmd == CMD_RD);
              w_state_next  = StBus;
            end else begin
              w_rsp0_next  = NAK_BYTE;
              w_rsp1_next  = NAK_CSUM;
              w_err_inc    = 1'b1;
              w_state_next = StRsp0;
            end
          end
          default: ;
        endcase
      end
    end else begin
      case (r_state)
        StCmd, StAddr, StData, StCsum: begin
          if (w_idle_exp) begin
            w_err_inc    = 1'b1;
            w_state_next = StHunt;
          end
        end
        StBus: begin
          if (i_bus_ready) begin
            w_bus_wr_next = 1'b0;
            w_bus_rd_next = 1'b0;
            w_rsp0_next   = ACK_BYTE;
            w_rsp1_next   = r_bus_wr ? 8'h00 : i_bus_rdata;
            w_state_next  = StRsp0;
          end else if (w_bus_exp) begin
            w_bus_wr_next = 1'b0;
            w_bus_rd_next = 1'b0;
            w_rsp0_next   = NAK_BYTE;
            w_rsp1_next   = NAK_BUS;
            w_err_inc     = 1'b1;
            w_state_next  = StRsp0;
          end
        end
        StRsp0: if (w_tx_fire) w_state_next = StRsp1;
        StRsp1: if (w_tx_fire) w_state_next = StHunt;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= StHunt;
      r_cmd    <= 8'h00;
      r_addr   <= 8'h00;
      r_data   <= 8'h00;
      r_rsp0   <= 8'h00;
      r_rsp1   <= 8'h00;
      r_bus_wr <= 1'b0;
      r_bus_rd <= 1'b0;
      r_gap    <= 1'b0;
      r_err    <= 8'h00;
    end else begin
      r_state  <= w_state_next;
      r_cmd    <= w_cmd_next;
      r_addr   <= w_addr_next;
      r_data   <= w_data_next;
      r_rsp0   <= w_rsp0_next;
      r_rsp1   <= w_rsp1_next;
      r_bus_wr <= w_bus_wr_next;
      r_bus_rd <= w_bus_rd_next;
      r_gap    <= o_read_rx | o_write_tx;
      if (w_err_inc && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Self-checking bench: UART RX queue model, bus responder and TX/bus scoreboards.
module tb_uart_cmd_bridge;

  localparam int unsigned IDLE_T = 40;
  localparam int unsigned BUS_T  = 20;
  localparam int NV = 8;

  logic       clk = 1'b0;
  logic       nreset;
  logic       i_rx_valid, i_tx_empty, i_bus_ready;
  logic [7:0] i_rxdata, i_rx_status, i_bus_rdata;
  logic       o_read_rx, o_write_tx, o_bus_wr, o_bus_rd;
  logic [7:0] o_txdata, o_bus_addr, o_bus_wdata, o_err_count;

  always #5 clk = ~clk;

  uart_cmd_bridge #(.IDLE_TIMEOUT(IDLE_T), .BUS_TIMEOUT(BUS_T)) dut (
    .clk         (clk),
    .nreset      (nreset),
    .i_rx_valid  (i_rx_valid),
    .i_rxdata    (i_rxdata),
    .i_rx_status (i_rx_status),
    .o_read_rx   (o_read_rx),
    .i_tx_empty  (i_tx_empty),
    .o_txdata    (o_txdata),
    .o_write_tx  (o_write_tx),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_wr    (o_bus_wr),
    .o_bus_rd    (o_bus_rd),
    .i_bus_rdata (i_bus_rdata),
    .i_bus_ready (i_bus_ready),
    .o_err_count (o_err_count)
  );

  typedef struct {
    int          n;      // frame length in bytes
    logic [47:0] seq;    // first byte in the most significant used position
    logic [7:0]  rdata;
    logic [7:0]  tx0;
    logic [7:0]  tx1;
    bit          bus;
    bit          wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    int          err;
  } vec_t;

  vec_t        vecs [NV];
  logic [15:0] rx_q [$];
  logic [7:0]  tx_exp [$];
  logic [16:0] bus_exp [$];
  int n_checks = 0, n_pass = 0, n_rx_double = 0, n_tx_double = 0, n_tx = 0;
  int last_len = 0, delay = 3, exp_err = 0;
  bit hang = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] st);
    rx_q.push_back({st, d});
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      if (rx_q.size() == 0 && tx_exp.size() == 0 && bus_exp.size() == 0) break;
    end
    if (i == 3000) check({name, "_timeout"}, rx_q.size() + tx_exp.size() + bus_exp.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // UART RX model: after a pop the old byte stays visible for one more clock.
  initial begin
    bit popped, prev_pop, stale;
    prev_pop = 1'b0;
    stale = 1'b0;
    forever begin
      @(negedge clk);
      popped = o_read_rx;
      if (popped && prev_pop) n_rx_double++;
      prev_pop = popped;
      @(posedge clk);
      #1;
      if (popped && rx_q.size() > 0) begin
        void'(rx_q.pop_front());
        stale = 1'b1;
      end else begin
        stale = 1'b0;
      end
      if (!stale) begin
        if (rx_q.size() > 0) begin
          i_rx_valid  = 1'b1;
          i_rxdata    = rx_q[0][7:0];
          i_rx_status = rx_q[0][15:8];
        end else begin
          i_rx_valid  = 1'b0;
          i_rxdata    = 8'h00;
          i_rx_status = 8'h00;
        end
      end
    end
  end

  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_write_tx) begin
        n_tx++;
        if (prev) n_tx_double++;
        check("tx_empty_at_push", i_tx_empty, 1);
        if (tx_exp.size() == 0) check("tx_unexpected_push", tx_exp.size(), 1);
        else check("tx_byte", o_txdata, tx_exp.pop_front());
      end
      prev = o_write_tx;
    end
  end

  initial begin
    bit prev, strobe;
    int len;
    logic [16:0] e;
    prev = 1'b0;
    len = 0;
    forever begin
      @(negedge clk);
      strobe = o_bus_wr | o_bus_rd;
      if (strobe && !prev) begin
        len = 0;
        check("bus_single_strobe", o_bus_wr & o_bus_rd, 0);
        if (bus_exp.size() == 0) begin
          check("bus_unexpected", bus_exp.size(), 1);
        end else begin
          e = bus_exp.pop_front();
          check("bus_kind_addr", {o_bus_wr, o_bus_rd, o_bus_addr}, {e[16], ~e[16], e[15:8]});
          if (e[16]) check("bus_wdata", o_bus_wdata, e[7:0]);
        end
      end
      if (strobe) begin
        len++;
        i_bus_ready = !hang && (len == delay);
      end else begin
        if (prev) last_len = len;
        i_bus_ready = 1'b0;
      end
      prev = strobe;
    end
  end

  initial begin
    vec_t v;
    int t0, i;
    nreset = 1'b0;
    i_rx_valid = 1'b0;
    i_rxdata = 8'h00;
    i_rx_status = 8'h00;
    i_tx_empty = 1'b1;
    i_bus_ready = 1'b0;
    i_bus_rdata = 8'h00;
    vecs[0] = '{5, 48'hA5_01_10_3C_2D, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b1, 8'h10, 8'h3C, 0};
    vecs[1] = '{4, 48'hA5_02_20_22, 8'h77, 8'h5A, 8'h77, 1'b1, 1'b0, 8'h20, 8'h00, 0};
    vecs[2] = '{5, 48'hA5_01_10_3C_00, 8'h00, 8'hEE, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1};
    vecs[3] = '{6, 48'h00_FF_A5_02_20_22, 8'h77, 8'h5A, 8'h77, 1'b1, 1'b0, 8'h20, 8'h00, 0};
    vecs[4] = '{4, 48'hA5_02_7F_7D, 8'hC3, 8'h5A, 8'hC3, 1'b1, 1'b0, 8'h7F, 8'h00, 0};
    vecs[5] = '{5, 48'hA5_01_FF_00_FE, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b1, 8'hFF, 8'h00, 0};
    vecs[6] = '{2, 48'hA5_03, 8'h00, 8'hEE, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1};
    vecs[7] = '{4, 48'hA5_02_20_00, 8'h00, 8'hEE, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1};

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {o_read_rx, o_write_tx, o_txdata, o_bus_addr, o_bus_wdata,
                            o_bus_wr, o_bus_rd, o_err_count}, 0);
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      i_bus_rdata = v.rdata;
      delay = 3 + (k % 2);
      if (v.bus) bus_exp.push_back({v.wr, v.addr, v.wdata});
      tx_exp.push_back(v.tx0);
      tx_exp.push_back(v.tx1);
      for (int b = 0; b < v.n; b++) send(v.seq[8*(v.n-1-b) +: 8], 8'h00);
      wait_done($sformatf("vec%0d", k));
      exp_err += v.err;
      check($sformatf("vec%0d_err_count", k), o_err_count, exp_err);
    end

    // Line errors: one in HUNT, one mid-frame; neither produces a response.
    t0 = n_tx;
    send(8'h00, 8'h04);
    send(8'hA5, 8'h00);
    send(8'h01, 8'h08);
    wait_done("byte_err");
    exp_err += 2;
    check("byte_err_count", o_err_count, exp_err);
    check("byte_err_no_tx", n_tx, t0);

    // Status bits outside [5:2] must not reject the frame.
    delay = 3;
    bus_exp.push_back({1'b1, 8'h10, 8'h3C});
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(8'h00);
    send(8'hA5, 8'hC3); send(8'h01, 8'hC3); send(8'h10, 8'hC3);
    send(8'h3C, 8'hC3); send(8'h2D, 8'hC3);
    wait_done("status_ignored");
    check("status_ignored_err", o_err_count, exp_err);

    // Stall after two bytes.
    t0 = n_tx;
    send(8'hA5, 8'h00);
    send(8'h01, 8'h00);
    for (i = 0; i < 200 && rx_q.size() != 0; i++) @(posedge clk);
    repeat (IDLE_T - 4) @(posedge clk);
    #1;
    check("stall_before_timeout", o_err_count, exp_err);
    repeat (10) @(posedge clk);
    #1;
    exp_err++;
    check("stall_err_count", o_err_count, exp_err);
    check("stall_no_tx", n_tx, t0);
    bus_exp.push_back({1'b1, 8'h10, 8'h3C});
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(8'h00);
    send(8'hA5, 8'h00); send(8'h01, 8'h00); send(8'h10, 8'h00);
    send(8'h3C, 8'h00); send(8'h2D, 8'h00);
    wait_done("after_stall");
    check("after_stall_err", o_err_count, exp_err);

    // Bus hang.
    hang = 1'b1;
    bus_exp.push_back({1'b1, 8'h10, 8'h3C});
    tx_exp.push_back(8'hEE);
    tx_exp.push_back(8'h02);
    send(8'hA5, 8'h00); send(8'h01, 8'h00); send(8'h10, 8'h00);
    send(8'h3C, 8'h00); send(8'h2D, 8'h00);
    wait_done("bus_hang");
    hang = 1'b0;
    exp_err++;
    check("bus_hang_err", o_err_count, exp_err);
    check("bus_hang_strobe_len", last_len, BUS_T);

    // TX holding register busy: response waits for tx_empty.
    i_tx_empty = 1'b0;
    i_bus_rdata = 8'h9C;
    t0 = n_tx;
    bus_exp.push_back({1'b0, 8'h31, 8'h00});
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(8'h9C);
    send(8'hA5, 8'h00); send(8'h02, 8'h00); send(8'h31, 8'h00); send(8'h33, 8'h00);
    for (i = 0; i < 300 && (rx_q.size() != 0 || bus_exp.size() != 0); i++) @(posedge clk);
    repeat (30) @(posedge clk);
    #1;
    check("tx_held_no_push", n_tx, t0);
    i_tx_empty = 1'b1;
    wait_done("tx_held");
    check("tx_held_pushes", n_tx, t0 + 2);

    // Error counter saturation.
    for (int k = 0; k < 260; k++) send(8'h00, 8'h20);
    wait_done("saturate");
    check("err_saturates", o_err_count, 8'hFF);

    // Asynchronous reset while a strobe is held.
    hang = 1'b1;
    bus_exp.push_back({1'b1, 8'h44, 8'h55});
    send(8'hA5, 8'h00); send(8'h01, 8'h00); send(8'h44, 8'h00);
    send(8'h55, 8'h00); send(8'h10, 8'h00);
    for (i = 0; i < 300 && !o_bus_wr; i++) @(posedge clk);
    check("reset_test_strobe_seen", o_bus_wr, 1);
    #3;
    nreset = 1'b0;
    #1;
    check("async_reset_outputs", {o_bus_wr, o_bus_rd, o_write_tx, o_err_count}, 0);
    repeat (2) @(posedge clk);
    hang = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_bus_rdata = 8'h11;
    bus_exp.push_back({1'b0, 8'h20, 8'h00});
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(8'h11);
    send(8'hA5, 8'h00); send(8'h02, 8'h00); send(8'h20, 8'h00); send(8'h22, 8'h00);
    wait_done("after_reset");
    check("after_reset_err", o_err_count, 0);

    check("no_back_to_back_read_rx", n_rx_double, 0);
    check("no_back_to_back_write_tx", n_tx_double, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
